// File: rtl/fmt_pkg.sv
// Shared constants, FSM state type and helpers for the distance ASCII formatter.
package fmt_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StEmitDigit,
    StEmitCr,
    StEmitLf
  } fmt_state_e;

  // Largest value representable with the given number of decimal digits.
  function automatic int unsigned max_decimal(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle,
// VALUE_W iterations per conversion, then a one-cycle done pulse.
module bin2bcd_seq #(
  parameter int unsigned VALUE_W = 16,
  parameter int unsigned DIGITS  = 3
) (
  input  logic                  hw_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BcdW-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      bin_d  = value;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {bcd_adj[BcdW-2:0], bin_q[VALUE_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(VALUE_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/distance_ascii_formatter.sv
// Turns one binary distance sample into a fixed-width decimal ASCII frame
// (digits, optional CR, LF) streamed byte by byte over valid/ready.
module distance_ascii_formatter
  import fmt_pkg::*;
#(
  parameter int unsigned VALUE_W   = 16,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned APPEND_CR = 0
) (
  input  logic               hw_clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               overflow,
  output logic               frame_done
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam int unsigned IdxW   = $clog2(DIGITS + 1);
  localparam int unsigned ExtW   = (VALUE_W > 32) ? VALUE_W : 32;
  localparam int unsigned MaxDec = max_decimal(DIGITS);

  fmt_state_e         state_q, state_d;
  logic               ovf_q, ovf_d;
  logic               fd_q, fd_d;
  logic [BcdW-1:0]    digits_q, digits_d;
  logic [IdxW-1:0]    idx_q, idx_d;

  logic               over_range;
  logic [VALUE_W-1:0] clamped;
  logic               accept;
  logic               conv_busy;
  logic               conv_done;
  logic [BcdW-1:0]    conv_bcd;

  assign over_range = ExtW'(in_value) > ExtW'(MaxDec);
  assign clamped    = over_range ? VALUE_W'(MaxDec) : in_value;
  assign accept     = (state_q == StIdle) && in_valid;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .hw_clk (hw_clk),
    .rst    (rst),
    .start  (accept),
    .value  (clamped),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    fd_d      = 1'b0;
    digits_d  = digits_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ovf_d   = over_range;
          state_d = StConvert;
        end
      end
      StConvert: begin
        if (conv_done && !conv_busy) begin
          digits_d = conv_bcd;
          idx_d    = '0;
          state_d  = StEmitDigit;
        end
      end
      StEmitDigit: begin
        out_valid = 1'b1;
        out_data  = ASCII_ZERO + {4'h0, digits_q[BcdW-1 -: 4]};
        if (out_ready) begin
          // Shift the next digit into the MSB nibble for the following byte.
          digits_d = digits_q << 4;
          idx_d    = idx_q + IdxW'(1);
          if (idx_q == IdxW'(DIGITS - 1)) begin
            state_d = (APPEND_CR != 0) ? StEmitCr : StEmitLf;
          end
        end
      end
      StEmitCr: begin
        out_valid = 1'b1;
        out_data  = ASCII_CR;
        if (out_ready) begin
          state_d = StEmitLf;
        end
      end
      StEmitLf: begin
        out_valid = 1'b1;
        out_data  = ASCII_LF;
        if (out_ready) begin
          state_d = StIdle;
          fd_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hw_clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
      digits_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      fd_q     <= fd_d;
      digits_q <= digits_d;
      idx_q    <= idx_d;
    end
  end

  assign overflow   = ovf_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_distance_ascii_formatter.sv
// Directed bench for distance_ascii_formatter: default 3-digit instance plus a
// 5-digit CR-terminated instance, checked against hand-computed frames.
module tb_distance_ascii_formatter;

  logic        hw_clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, overflow, frame_done;
  logic [15:0] in_value;
  logic [7:0]  out_data;

  logic        in_valid_b, in_ready_b, out_valid_b, overflow_b, frame_done_b;
  logic [15:0] in_value_b;
  logic [7:0]  out_data_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx [8];
  logic [7:0] rx_b [7];
  logic [7:0] exp_b [7];
  int         lat, gaps, unstable, ir_busy, late_valid;
  logic       fd1, fd2, ir1;

  always #5 hw_clk = ~hw_clk;

  distance_ascii_formatter u_dut (
    .hw_clk     (hw_clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  distance_ascii_formatter #(
    .VALUE_W   (16),
    .DIGITS    (5),
    .APPEND_CR (1)
  ) u_dut_b (
    .hw_clk     (hw_clk),
    .rst        (rst),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_value   (in_value_b),
    .out_valid  (out_valid_b),
    .out_ready  (1'b1),
    .out_data   (out_data_b),
    .overflow   (overflow_b),
    .frame_done (frame_done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one sample, then collect nbytes; stall>0 holds out_ready low that many
  // cycles per byte and pokes in_valid mid-frame.
  task automatic run_frame(input logic [15:0] val, input int nbytes, input int stall);
    int         w;
    logic [7:0] hold;
    gaps = 0; unstable = 0; ir_busy = 0;
    @(negedge hw_clk);
    in_valid = 1'b1;
    in_value = val;
    @(negedge hw_clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ir_busy++;
      @(negedge hw_clk);
      lat++;
    end
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (!out_valid && w < 200) begin
        @(negedge hw_clk);
        w++;
        gaps++;
      end
      if (stall > 0) begin
        hold = out_data;
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          if (i == 1 && s == 2) begin
            in_valid = 1'b1;
            in_value = 16'd500;
          end else begin
            in_valid = 1'b0;
          end
          @(negedge hw_clk);
          if (out_data !== hold || out_valid !== 1'b1) unstable++;
          if (in_ready) ir_busy++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      rx[i] = out_data;
      @(negedge hw_clk);
    end
    fd1 = frame_done;
    ir1 = in_ready;
    @(negedge hw_clk);
    fd2 = frame_done;
  endtask

  task automatic check_frame4(input string tag, input logic [31:0] exp);
    check({tag, " byte0"}, {24'h0, rx[0]}, {24'h0, exp[31:24]});
    check({tag, " byte1"}, {24'h0, rx[1]}, {24'h0, exp[23:16]});
    check({tag, " byte2"}, {24'h0, rx[2]}, {24'h0, exp[15:8]});
    check({tag, " byte3"}, {24'h0, rx[3]}, {24'h0, exp[7:0]});
  endtask

  initial begin
    int w;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_value   = 16'd0;
    out_ready  = 1'b1;
    in_valid_b = 1'b0;
    in_value_b = 16'd0;
    repeat (2) @(negedge hw_clk);
    check("reset in_ready", {31'h0, in_ready}, 32'd1);
    check("reset out_valid", {31'h0, out_valid}, 32'd0);
    check("reset out_data", {24'h0, out_data}, 32'h00);
    check("reset overflow", {31'h0, overflow}, 32'd0);
    check("reset frame_done", {31'h0, frame_done}, 32'd0);
    rst = 1'b0;

    // 42 with out_ready tied high
    run_frame(16'd42, 4, 0);
    check("v42 latency", lat, 32'd17);
    check_frame4("v42", 32'h3034320A);
    check("v42 bubbles", gaps, 32'd0);
    check("v42 in_ready busy", ir_busy, 32'd0);
    check("v42 frame_done", {31'h0, fd1}, 32'd1);
    check("v42 in_ready at done", {31'h0, ir1}, 32'd1);
    check("v42 frame_done width", {31'h0, fd2}, 32'd0);
    check("v42 overflow", {31'h0, overflow}, 32'd0);

    run_frame(16'd0, 4, 0);
    check_frame4("v0", 32'h3030300A);
    check("v0 overflow", {31'h0, overflow}, 32'd0);
    run_frame(16'd999, 4, 0);
    check_frame4("v999", 32'h3939390A);
    check("v999 overflow", {31'h0, overflow}, 32'd0);

    run_frame(16'd1234, 4, 0);
    check_frame4("v1234", 32'h3939390A);
    check("v1234 overflow", {31'h0, overflow}, 32'd1);
    run_frame(16'd7, 4, 0);
    check_frame4("v7", 32'h3030370A);
    check("v7 overflow", {31'h0, overflow}, 32'd0);

    // 305 with backpressure and an ignored mid-frame sample
    run_frame(16'd305, 4, 10);
    check_frame4("v305", 32'h3330350A);
    check("v305 stable", unstable, 32'd0);
    check("v305 in_ready busy", ir_busy, 32'd0);
    check("v305 frame_done", {31'h0, fd1}, 32'd1);
    late_valid = 0;
    repeat (25) begin
      @(negedge hw_clk);
      if (out_valid) late_valid++;
    end
    check("v305 no queued frame", late_valid, 32'd0);

    // reset while the second digit of 123 is presented
    @(negedge hw_clk);
    in_valid = 1'b1;
    in_value = 16'd123;
    @(negedge hw_clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 200) begin
      @(negedge hw_clk);
      w++;
    end
    @(negedge hw_clk);
    check("v123 second digit", {24'h0, out_data}, 32'h32);
    rst = 1'b1;
    #1;
    check("rst out_valid", {31'h0, out_valid}, 32'd0);
    check("rst in_ready", {31'h0, in_ready}, 32'd1);
    check("rst out_data", {24'h0, out_data}, 32'h00);
    @(negedge hw_clk);
    rst = 1'b0;
    run_frame(16'd88, 4, 0);
    check_frame4("v88", 32'h3038380A);

    // 5-digit instance with CR
    exp_b[0] = 8'h36; exp_b[1] = 8'h35; exp_b[2] = 8'h35; exp_b[3] = 8'h33;
    exp_b[4] = 8'h35; exp_b[5] = 8'h0D; exp_b[6] = 8'h0A;
    @(negedge hw_clk);
    in_valid_b = 1'b1;
    in_value_b = 16'd65535;
    @(negedge hw_clk);
    in_valid_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      w = 0;
      while (!out_valid_b && w < 200) begin
        @(negedge hw_clk);
        w++;
      end
      rx_b[i] = out_data_b;
      @(negedge hw_clk);
    end
    for (int i = 0; i < 7; i++) begin
      check($sformatf("d5 byte%0d", i), {24'h0, rx_b[i]}, {24'h0, exp_b[i]});
    end
    check("d5 overflow", {31'h0, overflow_b}, 32'd0);
    check("d5 frame_done", {31'h0, frame_done_b}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
